comp_mult_apb_master: RTL and testbench
=======================================

COMP_MULT_APB_MASTER -- requirements
Module: comp_mult_apb_master

Interface
REQ-001 SHALL have parameter APB_BADDR, default 1024, meaning base address of the multiplier register file.
REQ-002 SHALL have parameter SYS_AW, default 16, meaning APB address width.
REQ-003 SHALL have parameter REG_DW, default 16, meaning APB data width.
REQ-004 SHALL have parameter POLL_GAP, default 5, meaning cycles between consecutive STOP-register reads (min 2).
REQ-005 SHALL have parameter MAX_POLLS, default 1023, meaning STOP reads before timeout.
REQ-006 SHALL have port clk  in  1  system clock.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port sw_rst  in  1  synchronous reset, active high.
REQ-009 SHALL have ports cmd_val in 1 and cmd_rdy out 1, the job request handshake.
REQ-010 SHALL have ports cmd_op1_ba, cmd_op2_ba, cmd_res_ba, cmd_nr_op, all in REG_DW, the job parameters.
REQ-011 SHALL have ports done_val out 1, done_rdy in 1, done_err out 2 (00 ok, 01 slave error, 10 timeout), the completion handshake.
REQ-012 SHALL have ports apb_paddr out SYS_AW, apb_pwrite out 1, apb_pwdata out REG_DW, apb_psel out 1, apb_pready in 1, apb_prdata in REG_DW, apb_pslverr in 1.

Function
REQ-013 SHALL accept a job when cmd_val & cmd_rdy; cmd_rdy = 1 only in IDLE; job fields are latched on acceptance.
REQ-014 SHALL use FSM states IDLE, WR_OP1, WR_OP2, WR_RES, WR_NR, WR_START, RD_STOP, GAP, WR_CLR, DONE.
REQ-015 SHALL run one APB transfer per write state, complete it on the first cycle with apb_psel & apb_pready, then advance; addresses are APB_BADDR+0 (op1 base, pwdata = latched op1), +1 (op2), +2 (res), +3 (nr_op), +4 (pwdata = 1, start).
REQ-016 SHALL hold paddr, pwrite, pwdata and psel stable while pready = 0.
REQ-017 SHALL perform reads in RD_STOP at APB_BADDR+5 with apb_pwrite = 0; on completion: if prdata[0] = 1, go to WR_CLR; else go to GAP.
REQ-018 SHALL deassert psel in GAP for POLL_GAP-1 cycles, counted by a gap counter, and then return to RD_STOP.
REQ-019 SHALL count completed STOP reads with bit[0] = 0; when the count reaches MAX_POLLS, go to DONE with done_err = 10 without clearing.
REQ-020 SHALL write 0 to APB_BADDR+5 in WR_CLR and then go to DONE with done_err = 00.
REQ-021 SHALL, when any transfer completes with apb_pslverr = 1, abort immediately to DONE with done_err = 01 and issue no further transfers.
REQ-022 SHALL assert done_val in DONE, hold done_err stable, and return to IDLE on done_val & done_rdy.
REQ-023 SHALL issue exactly 7 transfers for a job whose first STOP read returns 1: 5 writes, 1 read and 1 clear.
REQ-024 SHALL clear the poll and gap counters on job acceptance; on the same cycle, psel = 1 and cmd_rdy = 0.
REQ-025 SHALL, for cmd_nr_op = 0, still run the full sequence; no special case.

Reset
REQ-026 SHALL, on rst_n asserted (async) or sw_rst (sync), return to IDLE and drive apb_psel = 0, apb_pwrite = 0, apb_paddr = 0, apb_pwdata = 0, done_val = 0, done_err = 00, cmd_rdy = 1, with counters = 0.
REQ-027 SHALL, on reset mid-transfer, drop psel on the next edge (async: immediately), discard the job and report no done.

Structure
REQ-028 SHALL take register offsets (OP1 = 0, OP2 = 1, RES = 2, NR = 3, CFG = 4, STOP = 5, STS = 6), the FSM state encoding and the done_err codes from shared package comp_mult_pkg.
REQ-029 SHALL be a single module with no sub-module; the counters are width-clog2(MAX_POLLS+1) and width-clog2(POLL_GAP) registers.

Verification
REQ-030 SHALL verify this scenario: job (100, 200, 300, 10), slave with pready always 1, STOP returns 1 on the 3rd read -> writes 1024..1028 with data 100, 200, 300, 10, 1, three reads of 1029 spaced 5 cycles apart, a write of 0 to 1029, and done_err = 00.
REQ-031 SHALL verify this scenario: slave inserts 2 wait states on every transfer -> signals stay stable during wait states and the same address/data sequence results.
REQ-032 SHALL verify this scenario: pslverr = 1 on the 1024+2 write -> no transfer to 1027, done_err = 01.
REQ-033 SHALL verify this scenario: MAX_POLLS = 4 and STOP is never set -> exactly 4 reads of 1029, no clear write, done_err = 10.
REQ-034 SHALL verify this scenario: rst_n asserted during GAP -> outputs return to reset values, cmd_rdy = 1, and a new job then completes normally.
REQ-035 SHALL verify this scenario: done_rdy held 0 for 10 cycles -> done_val and done_err stay stable, cmd_rdy = 0 throughout.

Source files
------------

// File: rtl/comp_mult_pkg.sv
// Shared definitions for the complex-multiplier APB master: register map,
// FSM state encoding and completion codes.
package comp_mult_pkg;

    localparam int OFF_OP1  = 0;
    localparam int OFF_OP2  = 1;
    localparam int OFF_RES  = 2;
    localparam int OFF_NR   = 3;
    localparam int OFF_CFG  = 4;
    localparam int OFF_STOP = 5;
    localparam int OFF_STS  = 6;

    typedef enum logic [3:0] {
        IDLE, WR_OP1, WR_OP2, WR_RES, WR_NR, WR_START, RD_STOP, GAP, WR_CLR, DONE
    } state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_SLV = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/comp_mult_apb_master.sv
// APB master that programs a multiplier job, polls its STOP register until the
// job finishes (or times out), clears STOP and reports completion status.
module comp_mult_apb_master
    import comp_mult_pkg::*;
#(
    parameter int APB_BADDR = 1024,
    parameter int SYS_AW    = 16,
    parameter int REG_DW    = 16,
    parameter int POLL_GAP  = 5,
    parameter int MAX_POLLS = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [REG_DW-1:0] cmd_op1_ba,
    input  logic [REG_DW-1:0] cmd_op2_ba,
    input  logic [REG_DW-1:0] cmd_res_ba,
    input  logic [REG_DW-1:0] cmd_nr_op,
    output logic              done_val,
    input  logic              done_rdy,
    output logic [1:0]        done_err,
    output logic [SYS_AW-1:0] apb_paddr,
    output logic              apb_pwrite,
    output logic [REG_DW-1:0] apb_pwdata,
    output logic              apb_psel,
    input  logic              apb_pready,
    input  logic [REG_DW-1:0] apb_prdata,
    input  logic              apb_pslverr
);

    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    localparam int GAP_W  = $clog2(POLL_GAP);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 2);

    localparam logic [SYS_AW-1:0] A_OP1  = SYS_AW'(APB_BADDR + OFF_OP1);
    localparam logic [SYS_AW-1:0] A_OP2  = SYS_AW'(APB_BADDR + OFF_OP2);
    localparam logic [SYS_AW-1:0] A_RES  = SYS_AW'(APB_BADDR + OFF_RES);
    localparam logic [SYS_AW-1:0] A_NR   = SYS_AW'(APB_BADDR + OFF_NR);
    localparam logic [SYS_AW-1:0] A_CFG  = SYS_AW'(APB_BADDR + OFF_CFG);
    localparam logic [SYS_AW-1:0] A_STOP = SYS_AW'(APB_BADDR + OFF_STOP);

    state_e            state, state_nxt;
    logic [REG_DW-1:0] op1, op2, res, nr;
    logic [POLL_W-1:0] poll_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              xfer_done;
    logic              prdata_unused;

    assign xfer_done     = apb_psel & apb_pready;
    assign prdata_unused = ^apb_prdata[REG_DW-1:1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)       state <= IDLE;
        else if (sw_rst) state <= IDLE;
        else             state <= state_nxt;
    end

    // A slave error on any transfer overrides the normal successor.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_val) state_nxt = WR_OP1;
            WR_OP1:   if (xfer_done) state_nxt = apb_pslverr ? DONE : WR_OP2;
            WR_OP2:   if (xfer_done) state_nxt = apb_pslverr ? DONE : WR_RES;
            WR_RES:   if (xfer_done) state_nxt = apb_pslverr ? DONE : WR_NR;
            WR_NR:    if (xfer_done) state_nxt = apb_pslverr ? DONE : WR_START;
            WR_START: if (xfer_done) state_nxt = apb_pslverr ? DONE : RD_STOP;
            RD_STOP: begin
                if (xfer_done) begin
                    if (apb_pslverr)              state_nxt = DONE;
                    else if (apb_prdata[0])       state_nxt = WR_CLR;
                    else if (poll_cnt == POLL_LAST) state_nxt = DONE;
                    else                          state_nxt = GAP;
                end
            end
            GAP:      if (gap_cnt == GAP_LAST) state_nxt = RD_STOP;
            WR_CLR:   if (xfer_done) state_nxt = DONE;
            DONE:     if (done_rdy) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy    = 1'b0;
        done_val   = 1'b0;
        apb_psel   = 1'b0;
        apb_pwrite = 1'b0;
        apb_paddr  = '0;
        apb_pwdata = '0;
        case (state)
            IDLE:     cmd_rdy = 1'b1;
            WR_OP1:   begin apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = A_OP1; apb_pwdata = op1; end
            WR_OP2:   begin apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = A_OP2; apb_pwdata = op2; end
            WR_RES:   begin apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = A_RES; apb_pwdata = res; end
            WR_NR:    begin apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = A_NR;  apb_pwdata = nr;  end
            WR_START: begin apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = A_CFG; apb_pwdata = REG_DW'(1); end
            RD_STOP:  begin apb_psel = 1'b1; apb_paddr = A_STOP; end
            WR_CLR:   begin apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = A_STOP; end
            DONE:     done_val = 1'b1;
            default:  ;
        endcase
    end

    // Job fields, poll/gap counters and the completion code.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op1 <= '0; op2 <= '0; res <= '0; nr <= '0;
            poll_cnt <= '0; gap_cnt <= '0; done_err <= ERR_OK;
        end else if (sw_rst) begin
            op1 <= '0; op2 <= '0; res <= '0; nr <= '0;
            poll_cnt <= '0; gap_cnt <= '0; done_err <= ERR_OK;
        end else begin
            if (state == IDLE && cmd_val) begin
                op1      <= cmd_op1_ba;
                op2      <= cmd_op2_ba;
                res      <= cmd_res_ba;
                nr       <= cmd_nr_op;
                poll_cnt <= '0;
                gap_cnt  <= '0;
                done_err <= ERR_OK;
            end
            if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            if (xfer_done) begin
                if (apb_pslverr) begin
                    done_err <= ERR_SLV;
                end else if (state == RD_STOP && !apb_prdata[0]) begin
                    poll_cnt <= poll_cnt + POLL_W'(1);
                    gap_cnt  <= '0;
                    if (poll_cnt == POLL_LAST) done_err <= ERR_TMO;
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_mult_apb_master.sv
// Bench for comp_mult_apb_master: APB slave model plus an expected-transfer list
// derived from the job parameters, checked on every selected cycle.
module tb_comp_mult_apb_master;
    import comp_mult_pkg::*;

    localparam int BASE = 1024;
    localparam int PGAP = 5;
    localparam int MAXP = 4;

    logic        clk = 1'b0, rst_n = 1'b1, sw_rst = 1'b0, cmd_val = 1'b0, done_rdy = 1'b0;
    logic [15:0] cmd_op1_ba = '0, cmd_op2_ba = '0, cmd_res_ba = '0, cmd_nr_op = '0;
    logic        cmd_rdy, done_val, apb_pwrite, apb_psel;
    logic [1:0]  done_err;
    logic [15:0] apb_paddr, apb_pwdata;
    logic        apb_pready = 1'b0, apb_pslverr = 1'b0;
    logic [15:0] apb_prdata = '0;

    comp_mult_apb_master #(
        .APB_BADDR(BASE), .SYS_AW(16), .REG_DW(16), .POLL_GAP(PGAP), .MAX_POLLS(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .cmd_op1_ba(cmd_op1_ba), .cmd_op2_ba(cmd_op2_ba), .cmd_res_ba(cmd_res_ba), .cmd_nr_op(cmd_nr_op),
        .done_val(done_val), .done_rdy(done_rdy), .done_err(done_err),
        .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_psel(apb_psel),
        .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; bit wr; int data; } xfer_t;
    xfer_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    int waits = 0, stop_idx = 0, err_addr = -1;
    int n_xfer = 0, rd_seen = 0, wcnt = 0, cyc = 0, last_rd = -1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Expected transfer list: five setup writes, STOP reads until set or MAXP
    // reads, then a clear; any slave-errored address ends the list.
    task automatic build(input int o1, input int o2, input int rs, input int nr,
                         input int stop, input int erra, output logic [1:0] err);
        int d[5];
        d[0] = o1; d[1] = o2; d[2] = rs; d[3] = nr; d[4] = 1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{addr: BASE + i, wr: 1'b1, data: d[i]});
            if (BASE + i == erra) begin err = 2'b01; return; end
        end
        for (int r = 1; r <= MAXP; r++) begin
            exp_q.push_back('{addr: BASE + 5, wr: 1'b0, data: 0});
            if (r == stop) begin
                exp_q.push_back('{addr: BASE + 5, wr: 1'b1, data: 0});
                err = 2'b00;
                return;
            end
        end
        err = 2'b10;
    endtask

    // Slave model and per-cycle checker in one process, away from the rising edge.
    always @(negedge clk) begin
        xfer_t e;
        cyc++;
        apb_pready = 1'b0; apb_prdata = '0; apb_pslverr = 1'b0;
        if (cmd_val && cmd_rdy) begin
            n_xfer = 0; rd_seen = 0; wcnt = 0; last_rd = -1;
        end else if (apb_psel) begin
            if (n_xfer >= exp_q.size()) begin
                check("extra_xfer", n_xfer, exp_q.size());
            end else begin
                e = exp_q[n_xfer];
                check("paddr", int'(apb_paddr), e.addr);
                check("pwrite", int'(apb_pwrite), int'(e.wr));
                if (e.wr) check("pwdata", int'(apb_pwdata), e.data);
                if (wcnt < waits) wcnt++;
                else begin
                    apb_pready  = 1'b1;
                    apb_pslverr = (int'(apb_paddr) == err_addr);
                    if (!e.wr) begin
                        rd_seen++;
                        apb_prdata = (rd_seen == stop_idx) ? 16'h8001 : 16'hFFFE;
                        if (last_rd >= 0) check("poll_spacing", cyc - last_rd, PGAP + waits);
                        last_rd = cyc;
                    end
                    n_xfer++;
                    wcnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_psel"},   int'(apb_psel),   0);
        check({nm, "_pwrite"}, int'(apb_pwrite), 0);
        check({nm, "_paddr"},  int'(apb_paddr),  0);
        check({nm, "_pwdata"}, int'(apb_pwdata), 0);
        check({nm, "_dval"},   int'(done_val),   0);
        check({nm, "_derr"},   int'(done_err),   0);
        check({nm, "_cmdrdy"}, int'(cmd_rdy),    1);
    endtask

    task automatic start_job(input string nm, input int o1, input int o2, input int rs, input int nr);
        cmd_op1_ba = 16'(o1); cmd_op2_ba = 16'(o2); cmd_res_ba = 16'(rs); cmd_nr_op = 16'(nr);
        cmd_val = 1'b1;
        tick();
        cmd_val = 1'b0;
        check({nm, "_acc_cmdrdy"}, int'(cmd_rdy), 0);
        check({nm, "_acc_psel"},   int'(apb_psel), 1);
    endtask

    task automatic run_job(input string nm, input int o1, input int o2, input int rs, input int nr,
                           input int w, input int stop, input int erra,
                           input int lit_err, input int lit_cnt, input int hold);
        logic [1:0] merr;
        build(o1, o2, rs, nr, stop, erra, merr);
        check({nm, "_model_err"}, int'(merr), lit_err);
        check({nm, "_model_cnt"}, exp_q.size(), lit_cnt);
        waits = w; stop_idx = stop; err_addr = erra;
        start_job(nm, o1, o2, rs, nr);
        for (int i = 0; i < 400 && !done_val; i++) tick();
        check({nm, "_done_seen"}, int'(done_val), 1);
        check({nm, "_done_err"}, int'(done_err), int'(merr));
        check({nm, "_xfer_cnt"}, n_xfer, exp_q.size());
        for (int i = 0; i < hold; i++) begin
            tick();
            check({nm, "_hold_dval"},   int'(done_val), 1);
            check({nm, "_hold_derr"},   int'(done_err), int'(merr));
            check({nm, "_hold_cmdrdy"}, int'(cmd_rdy),  0);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        check({nm, "_ret_dval"},   int'(done_val), 0);
        check({nm, "_ret_cmdrdy"}, int'(cmd_rdy),  1);
        check({nm, "_ret_xfer"},   n_xfer, exp_q.size());
    endtask

    task automatic wait_xfers(input string nm, input int n);
        for (int i = 0; i < 200 && n_xfer < n; i++) tick();
        check({nm, "_reached"}, n_xfer, n);
    endtask

    initial begin
        logic [1:0] merr;
        tick(); tick(); tick();
        check_reset("por");
        rst_n = 1'b0;
        tick();
        check_reset("idle");

        // Basic job, STOP on third read; completion held off for 10 cycles.
        run_job("basic", 100, 200, 300, 10, 0, 3, -1, 0, 9, 10);
        // Same job through a slave with two wait states per transfer.
        run_job("wait2", 100, 200, 300, 10, 2, 3, -1, 0, 9, 0);
        // Slave error on the RES write.
        run_job("slverr", 100, 200, 300, 10, 0, 3, BASE + 2, 1, 3, 0);
        // STOP never set: exactly MAXP reads, no clear.
        run_job("timeout", 7, 8, 9, 4, 0, 0, -1, 2, 9, 2);

        // Asynchronous reset while in the poll gap.
        build(1, 2, 3, 4, 0, -1, merr);
        waits = 0; stop_idx = 0; err_addr = -1;
        start_job("rstgap", 1, 2, 3, 4);
        wait_xfers("rstgap", 6);
        tick();
        check("rstgap_in_gap", int'(apb_psel), 0);
        rst_n = 1'b1;
        #1;
        check_reset("rstgap_async");
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rstgap_no_done", int'(done_val), 0);
        end
        // New job after reset, first STOP read set, zero operations.
        run_job("first_stop", 11, 22, 33, 0, 0, 1, -1, 0, 7, 0);

        // Synchronous reset during a wait-stated transfer.
        build(5, 6, 7, 8, 1, -1, merr);
        waits = 2; stop_idx = 1; err_addr = -1;
        start_job("swrst", 5, 6, 7, 8);
        wait_xfers("swrst", 1);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check_reset("swrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("swrst_no_done", int'(done_val), 0);
        end
        run_job("after_sw", 0, 0, 0, 0, 1, 2, -1, 0, 8, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
